// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator processor and its memory block.
// Holds the bus opcode encodings, the data/count widths and the processor
// state enumeration. No ports.
package acc_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned COUNT_W = 16;

  localparam logic [OP_W-1:0] OP_NOP   = 2'b00;
  localparam logic [OP_W-1:0] OP_FETCH = 2'b01;
  localparam logic [OP_W-1:0] OP_SEND  = 2'b10;
  localparam logic [OP_W-1:0] OP_END   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_REQ_A  = 4'd1,
    ST_ISS_A  = 4'd2,
    ST_WAIT_A = 4'd3,
    ST_REQ_B  = 4'd4,
    ST_ISS_B  = 4'd5,
    ST_WAIT_B = 4'd6,
    ST_ADD    = 4'd7,
    ST_REQ_S  = 4'd8,
    ST_ISS_S  = 4'd9,
    ST_WAIT_S = 4'd10,
    ST_FIN    = 4'd11,
    ST_ERR    = 4'd12
  } acc_state_e;

  // True while a bus transaction is being requested or is outstanding.
  function automatic logic is_bus_phase(input acc_state_e s);
    return s inside {ST_REQ_A, ST_ISS_A, ST_WAIT_A,
                     ST_REQ_B, ST_ISS_B, ST_WAIT_B,
                     ST_REQ_S, ST_ISS_S, ST_WAIT_S};
  endfunction

endpackage

// File: rtl/acc_adder.sv
// Combinational 32-bit unsigned adder for the accumulator.
// Overflow policy: ACC_SATURATE_EN defined -> clamp to all-ones,
// otherwise wrap modulo 2^DATA_W.
// Ports: a, b   - operands
//        sum_c  - combinational result
module acc_adder
  import acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum_c
);

`ifdef ACC_SATURATE_EN
  logic [DATA_W:0] full_c;

  // Carry out of the top bit means the true sum does not fit.
  assign full_c = {1'b0, a} + {1'b0, b};
  assign sum_c  = full_c[DATA_W] ? {DATA_W{1'b1}} : full_c[DATA_W-1:0];
`else
  assign sum_c = a + b;
`endif

endmodule

// File: rtl/accumulator_processor.sv
// Accumulator processor: fetches operand pairs over a shared tristate bus,
// adds them and sends the result back, until a fetched A of zero ends the
// run. Adder overflow policy is selected by the ACC_SATURATE_EN macro
// (see acc_adder).
// Ports: clk, reset (async, active-high)
//        start     - one-cycle pulse, starts a run from IDLE/FIN/ERR
//        grant     - bus grant from the arbiter
//        req       - bus request
//        op, data  - shared tristate opcode / operand bus
//        busy, done, err - status
//        sum_count - SENDs completed since reset (wraps)
module accumulator_processor
  import acc_pkg::*;
#(
  parameter int unsigned END_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               grant,
  output logic               req,
  inout  wire  [OP_W-1:0]    op,
  inout  wire  [DATA_W-1:0]  data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [COUNT_W-1:0] sum_count
);

  localparam int unsigned CNT_W = $clog2(END_TIMEOUT + 1);

  acc_state_e        state;
  acc_state_e        state_n;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] sum_c;
  logic [OP_W-1:0]   op_q;
  logic              op_oe;
  logic              data_oe;
  logic              end_c;
  logic              in_wait_c;
  logic              timeout_c;

  // Tristate drivers, enabled only from registered state so reset releases them at once.
  assign op   = op_oe   ? op_q  : {OP_W{1'bz}};
  assign data = data_oe ? res_q : {DATA_W{1'bz}};

  assign end_c     = (op == OP_END);
  assign in_wait_c = state inside {ST_WAIT_A, ST_WAIT_B, ST_WAIT_S};
  assign timeout_c = (wait_cnt == CNT_W'(END_TIMEOUT - 1));

  acc_adder u_adder (
    .a     (a_q),
    .b     (b_q),
    .sum_c (sum_c)
  );

  // Next-state selection.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = ST_REQ_A;
      ST_REQ_A:  if (req && grant) state_n = ST_ISS_A;
      ST_ISS_A:  state_n = ST_WAIT_A;
      ST_WAIT_A: begin
        if (end_c)          state_n = (data == '0) ? ST_FIN : ST_REQ_B;
        else if (timeout_c) state_n = ST_ERR;
      end
      ST_REQ_B:  if (req && grant) state_n = ST_ISS_B;
      ST_ISS_B:  state_n = ST_WAIT_B;
      ST_WAIT_B: begin
        if (end_c)          state_n = (data == '0) ? ST_REQ_S : ST_ADD;
        else if (timeout_c) state_n = ST_ERR;
      end
      ST_ADD:    state_n = ST_REQ_S;
      ST_REQ_S:  if (req && grant) state_n = ST_ISS_S;
      ST_ISS_S:  state_n = ST_WAIT_S;
      ST_WAIT_S: begin
        if (end_c)          state_n = ST_REQ_A;
        else if (timeout_c) state_n = ST_ERR;
      end
      ST_FIN, ST_ERR: if (start) state_n = ST_REQ_A;
      default:   state_n = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      op_q      <= OP_NOP;
      op_oe     <= 1'b0;
      data_oe   <= 1'b0;
      req       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sum_count <= '0;
    end else begin
      state   <= state_n;
      // req drops for the cycle after END so each transaction gets its own request.
      req     <= is_bus_phase(state_n) && !(in_wait_c && end_c);
      busy    <= !(state_n inside {ST_IDLE, ST_FIN, ST_ERR});
      done    <= (state_n == ST_FIN);
      err     <= (state_n == ST_ERR);
      op_oe   <= state_n inside {ST_ISS_A, ST_ISS_B, ST_ISS_S};
      op_q    <= (state_n == ST_ISS_S) ? OP_SEND : OP_FETCH;
      data_oe <= state_n inside {ST_ISS_S, ST_WAIT_S};

      wait_cnt <= in_wait_c ? wait_cnt + CNT_W'(1) : '0;

      if (state == ST_WAIT_A && end_c) a_q <= data;
      if (state == ST_WAIT_B && end_c) b_q <= data;

      // A zero B passes A straight through; otherwise the adder result is taken in ADD.
      if (state == ST_WAIT_B && end_c && data == '0) res_q <= a_q;
      if (state == ST_ADD)                           res_q <= sum_c;

      if (state == ST_WAIT_S && end_c) sum_count <= sum_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_accumulator_processor.sv
// Self-checking bench for accumulator_processor: a reducing memory model
// answers FETCH/SEND with random latency, and a list-level reference model
// predicts the sequence of bus transactions and the final stored value.
`timescale 1ns/1ps
module tb_accumulator_processor;
  import acc_pkg::*;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        grant = 1'b1;
  logic        req, busy, done, err;
  logic [15:0] sum_count;
  wire  [1:0]  op_bus;
  wire  [31:0] data_bus;

  logic        mem_op_en = 1'b0;
  logic        mem_data_en = 1'b0;
  logic [1:0]  mem_op = 2'b00;
  logic [31:0] mem_data = 32'd0;

  assign op_bus   = mem_op_en   ? mem_op   : 2'bzz;
  assign data_bus = mem_data_en ? mem_data : 32'hzzzz_zzzz;

  // Undriven bus reads as NOP / all-ones so a released bus is observable.
  for (genvar i = 0; i < 2; i++) begin : g_pd
    pulldown pd (op_bus[i]);
  end
  for (genvar i = 0; i < 32; i++) begin : g_pu
    pullup pu (data_bus[i]);
  end

  accumulator_processor #(.END_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .grant     (grant),
    .req       (req),
    .op        (op_bus),
    .data      (data_bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sum_count (sum_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_send;
    logic [31:0] val;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] exp_final;
  int          exp_count = 0;

  function automatic logic [31:0] add_ref(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ACC_SATURATE_EN
    if (s[32]) return 32'hFFFF_FFFF;
`endif
    return s[31:0];
  endfunction

  // Reduce the list: pop A, pop B, send A+B (or A if B==0); the result goes
  // back to the head of the list unless the list is empty, where it is final.
  task automatic build_expected(input logic [31:0] init[$]);
    logic [31:0] l[$];
    logic [31:0] a, b, r;
    l = init;
    exp_q.delete();
    exp_final = 32'd0;
    for (int g = 0; g < 64; g++) begin
      a = 32'd0;
      if (l.size() > 0) a = l.pop_front();
      exp_q.push_back('{1'b0, a});
      if (a == 32'd0) break;
      b = 32'd0;
      if (l.size() > 0) b = l.pop_front();
      exp_q.push_back('{1'b0, b});
      r = (b == 32'd0) ? a : add_ref(a, b);
      exp_q.push_back('{1'b1, r});
      if (l.size() > 0) l.push_front(r);
      else exp_final = r;
    end
  endtask

  task automatic observe(input bit is_send, input logic [31:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_event", {31'd0, is_send, v}, 64'hDEAD);
    end else begin
      e = exp_q.pop_front();
      check_eq(is_send ? "send_event" : "fetch_event", {31'd0, is_send, v}, {31'd0, e.is_send, e.val});
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_q[$];
  logic [31:0] mem_final = 32'd0;
  logic [31:0] sends_seen[$];
  int          mem_mode = 0;  // 0 normal, 1 never answers, 2 ignores SEND

  always begin : mem_proc
    int          d;
    logic [31:0] v;
    @(negedge clk);
    if (!reset && op_bus == OP_FETCH && mem_mode != 1) begin
      check_eq("req_at_fetch", {63'd0, req}, 64'd1);
      v = 32'd0;
      if (mem_q.size() > 0) v = mem_q.pop_front();
      observe(1'b0, v);
      d = $urandom_range(0, 3);
      repeat (d + 1) @(negedge clk);
      mem_op = OP_END; mem_data = v; mem_op_en = 1'b1; mem_data_en = 1'b1;
      @(negedge clk);
      mem_op_en = 1'b0; mem_data_en = 1'b0;
    end else if (!reset && op_bus == OP_SEND && mem_mode == 0) begin
      v = data_bus;
      observe(1'b1, v);
      sends_seen.push_back(v);
      d = $urandom_range(0, 3);
      repeat (d + 1) @(negedge clk);
      check_eq("send_data_held", {32'd0, data_bus}, {32'd0, v});
      mem_op = OP_END; mem_op_en = 1'b1;
      @(negedge clk);
      mem_op_en = 1'b0;
      exp_count++;
      if (mem_q.size() > 0) mem_q.push_front(v);
      else mem_final = v;
      check_eq("sum_count_step", {48'd0, sum_count}, {48'd0, exp_count[15:0]});
    end
  end

  // Every cycle: FIN/ERR must have released the bus and never coexist.
  always @(negedge clk) begin
    if (!reset && (done || err))
      check_eq("terminal_outputs", {61'd0, req, busy, done & err}, 64'd0);
  end

  // ---------------- stimulus ----------------
  bit rand_grant = 1'b0;

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_run(input string name);
    int n;
    n = 0;
    while (!(done || err) && n < 3000) begin
      if (rand_grant) grant = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    grant = 1'b1;
    if (!(done || err)) check_eq({name, "_timeout"}, 64'd0, 64'd1);
    check_eq({name, "_status"}, {60'd0, done, err, busy, req}, 64'b1000);
    check_eq({name, "_events_left"}, 64'(exp_q.size()), 64'd0);
    check_eq({name, "_final"}, {32'd0, mem_final}, {32'd0, exp_final});
    check_eq({name, "_sum_count"}, {48'd0, sum_count}, {48'd0, exp_count[15:0]});
  endtask

  task automatic run_list(input string name, input logic [31:0] init[$]);
    mem_q = init;
    mem_final = 32'd0;
    sends_seen.delete();
    build_expected(init);
    pulse_start();
    finish_run(name);
  endtask

  initial begin
    logic [31:0] lst[$];
    int          c0, c1, n, len;

    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] lst[$];
    int          c0, c1, n, len;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {59'd0, req, busy, done, err, 1'b0}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_outputs", {43'd0, req, busy, done, err, sum_count, 1'b0}, 64'd0);
    check_eq("idle_op_z", {62'd0, op_bus}, {62'd0, OP_NOP});
    check_eq("idle_data_z", {32'd0, data_bus}, 64'hFFFF_FFFF);

    // {3,5,7}: SENDs 8 then 15, memory ends holding 15.
    lst = '{32'd3, 32'd5, 32'd7};
    run_list("list357", lst);
    check_eq("list357_nsends", 64'(sends_seen.size()), 64'd2);
    if (sends_seen.size() == 2) begin
      check_eq("list357_send0", {32'd0, sends_seen[0]}, 64'd8);
      check_eq("list357_send1", {32'd0, sends_seen[1]}, 64'd15);
    end
    check_eq("list357_mem", {32'd0, mem_final}, 64'd15);
    check_eq("list357_count", {48'd0, sum_count}, 64'd2);

    // Single value 9: passes through unchanged.
    lst = '{32'd9};
    run_list("list9", lst);
    check_eq("list9_nsends", 64'(sends_seen.size()), 64'd1);
    if (sends_seen.size() == 1) check_eq("list9_send", {32'd0, sends_seen[0]}, 64'd9);
    check_eq("list9_count", {48'd0, sum_count}, 64'd3);

    // Overflow policy.
    lst = '{32'hFFFF_FFF0, 32'h20};
    run_list("ovf", lst);
    if (sends_seen.size() == 1) begin
`ifdef ACC_SATURATE_EN
      check_eq("ovf_send", {32'd0, sends_seen[0]}, 64'hFFFF_FFFF);
`else
      check_eq("ovf_send", {32'd0, sends_seen[0]}, 64'h10);
`endif
    end else check_eq("ovf_nsends", 64'(sends_seen.size()), 64'd1);

    // Grant withheld in REQ_A: bus stays released, req held.
    lst = '{32'd4};
    mem_q = lst; mem_final = 32'd0; sends_seen.delete(); build_expected(lst);
    grant = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      check_eq("nogrant_hold", {28'd0, req, busy, op_bus, data_bus}, {28'd0, 1'b1, 1'b1, OP_NOP, 32'hFFFF_FFFF});
      @(negedge clk);
    end
    grant = 1'b1;
    @(negedge clk);
    check_eq("grant_fetch", {62'd0, op_bus}, {62'd0, OP_FETCH});
    finish_run("grant");

    // Memory never answers: ERR after exactly TO wait cycles.
    mem_mode = 1;
    pulse_start();
    n = 0;
    while (op_bus != OP_FETCH && n < 20) begin @(negedge clk); n++; end
    c0 = cyc;
    n = 0;
    while (!err && n < 300) begin @(negedge clk); n++; end
    c1 = cyc;
    check_eq("timeout_cycles", 64'(c1 - c0), 64'(TO + 1));
    check_eq("timeout_status", {61'd0, err, req, done}, 64'b100);
    mem_mode = 0;
    lst = '{32'd2, 32'd3};
    run_list("after_err", lst);
    if (sends_seen.size() == 1) check_eq("after_err_send", {32'd0, sends_seen[0]}, 64'd5);
    else check_eq("after_err_nsends", 64'(sends_seen.size()), 64'd1);

    // Randomised runs with random grant and latency.
    for (int r = 0; r < 24; r++) begin
      lst.delete();
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 9))
          0:       lst.push_back(32'd0);
          1, 2, 3: lst.push_back($urandom());
          default: lst.push_back(32'($urandom_range(1, 1000)));
        endcase
      end
      rand_grant = 1'b1;
      run_list("random", lst);
      rand_grant = 1'b0;
    end

    // Reset during WAIT_S with the result on the bus.
    mem_mode = 2;
    lst = '{32'd6, 32'd1};
    mem_q = lst; mem_final = 32'd0; sends_seen.delete(); build_expected(lst);
    pulse_start();
    n = 0;
    while (op_bus != OP_SEND && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check_eq("waits_data", {32'd0, data_bus}, 64'd7);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_bus_z", {30'd0, op_bus, data_bus}, {30'd0, OP_NOP, 32'hFFFF_FFFF});
    check_eq("rst_outputs", {43'd0, req, busy, done, err, sum_count, 1'b0}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_mode = 0;
    exp_count = 0;
    lst = '{32'd1, 32'd1};
    run_list("post_reset", lst);
    check_eq("post_reset_count", {48'd0, sum_count}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
